// File: rtl/bus_demux_4out_pkg.sv
// ---------------------------------------------------------------------------
// bus_demux_4out_pkg
//
// Purpose:
//   Shared definitions for the four-output bus distributor and its companion
//   four-input bus mux. Holds the default data width, the channel count and
//   the destination select encodings. Both the mux and the demux use these
//   encodings, so channel numbering always matches across the datapath.
//
// Contents:
//   DATA_WIDTH  default width of the source bus and every channel (16)
//   NUM_CH      number of destination channels (4)
//   SEL_W       width of the destination select (2)
//   ch_sel_e    destination select encoding CH_A..CH_D
//   decodeSel   one-hot decode of a destination select
// ---------------------------------------------------------------------------
package bus_demux_4out_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;

    // Destination encodings:
    //   CH_A = register-file write port
    //   CH_B = memory data-in
    //   CH_C = I/O port
    //   CH_D = ALU operand latch
    typedef enum logic [SEL_W-1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } ch_sel_e;

    // Turns a destination select into a one-hot channel vector.
    function automatic logic [NUM_CH-1:0] decodeSel(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oneHot;
        oneHot = '0;
        oneHot[sel] = 1'b1;
        return oneHot;
    endfunction

endpackage : bus_demux_4out_pkg

// File: rtl/bus_demux_slot.sv
// ---------------------------------------------------------------------------
// bus_demux_slot
//
// Purpose:
//   One-entry holding register for a single distributor channel. It holds
//   one word with a valid flag and reports whether it can take a new word
//   this cycle. A slot that is being drained this cycle counts as free, so a
//   channel can sustain one word per cycle when its consumer stays ready.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset; clears data and valid
//   load         in   write load_data into the slot at this edge
//   load_data    in   WIDTH  word to store
//   drain_ready  in   consumer is ready; a valid word leaves at this edge
//   data         out  WIDTH  held word (kept after it drains)
//   valid        out  slot holds a word not yet taken by the consumer
//   free         out  slot can accept a load this cycle
// ---------------------------------------------------------------------------
module bus_demux_slot
    import bus_demux_4out_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // Next-state for the holding register. A load always wins over a drain,
    // which is what lets a drain and a load on the same edge keep valid high
    // with the new word replacing the old one. A drain without a load only
    // clears valid; the data is left in place.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (drain_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with synchronous reset that discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

    // Empty, or the consumer takes the current word at this edge.
    assign free  = !valid_q || drain_ready;

endmodule : bus_demux_slot

// File: rtl/bus_demux_4out.sv
// ---------------------------------------------------------------------------
// bus_demux_4out
//
// Purpose:
//   Four-output bus distributor. It takes one source word per cycle with a
//   2-bit destination select and delivers it to one of four channels. Each
//   channel has its own one-entry holding register with valid/ready
//   handshaking, so a stalled consumer only blocks words aimed at it.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_data    in   WIDTH  source word
//   in_sel     in   2      destination (CH_A..CH_D)
//   in_valid   in   source offers in_data/in_sel this cycle
//   in_ready   out  word is accepted this cycle (depends on in_sel, out_ready)
//   out_a..d   out  WIDTH  registered channel data
//   out_valid  out  4      per-channel valid, bit i = channel i
//   out_ready  in   4      per-channel consumer ready
//   busy       out  any channel holds a word
// ---------------------------------------------------------------------------
module bus_demux_4out
    import bus_demux_4out_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_c,
    output logic [WIDTH-1:0]  out_d,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic              busy
);

    logic [NUM_CH-1:0] slotFree;
    logic [NUM_CH-1:0] slotValid;
    logic [NUM_CH-1:0] slotLoad;
    logic [WIDTH-1:0]  slotData [NUM_CH];

    // Ready is the free flag of the selected slot only, gated off during
    // reset so nothing offered in a reset cycle is accepted.
    assign in_ready = !reset && slotFree[in_sel];

    // 2-to-4 load decoder: only the selected slot loads, only on a transfer.
    assign slotLoad = (in_valid && in_ready) ? decodeSel(in_sel) : '0;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gSlot
        bus_demux_slot #(
            .WIDTH(WIDTH)
        ) uSlot (
            .clk        (clk),
            .reset      (reset),
            .load       (slotLoad[ch]),
            .load_data  (in_data),
            .drain_ready(out_ready[ch]),
            .data       (slotData[ch]),
            .valid      (slotValid[ch]),
            .free       (slotFree[ch])
        );
    end

    assign out_a     = slotData[CH_A];
    assign out_b     = slotData[CH_B];
    assign out_c     = slotData[CH_C];
    assign out_d     = slotData[CH_D];
    assign out_valid = slotValid;
    assign busy      = |slotValid;

endmodule : bus_demux_4out

// File: tb/tb_bus_demux_4out.sv
// ---------------------------------------------------------------------------
// tb_bus_demux_4out
//
// Purpose:
//   Self-checking bench for bus_demux_4out. It runs directed scenarios for
//   reset, routing, back-pressure, drain+load and streaming, then random
//   traffic. A behavioural model keeps one word and a valid flag per channel
//   plus a list of accepted words, and checks every drained word against the
//   oldest word accepted for that channel.
// ---------------------------------------------------------------------------
module tb_bus_demux_4out;
    import bus_demux_4out_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_c;
    logic [15:0] out_d;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int          ch;
        logic [15:0] data;
    } word_t;

    logic        mValid [4];
    logic [15:0] mData  [4];
    word_t       accepted [$];
    logic [15:0] sampData [4];
    int          drainCount [4];

    bus_demux_4out #(
        .WIDTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dutOut(input int i);
        case (i)
            0:       return out_a;
            1:       return out_b;
            2:       return out_c;
            default: return out_d;
        endcase
    endfunction

    // Drives one cycle of inputs, checks the DUT against the model in the
    // middle of the cycle, then advances the model across the rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] sel,
                                 input logic [15:0] d, input logic [3:0] ordy);
        logic       expReady;
        logic [3:0] expValid;
        logic [3:0] drained;
        logic       acc;
        int         idx;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        expReady = !rst && (!mValid[sel] || ordy[sel]);
        checkOutput("in_ready", in_ready, expReady);
        for (int i = 0; i < 4; i++) begin
            expValid[i] = mValid[i];
            sampData[i] = dutOut(i);
        end
        checkOutput("out_valid", out_valid, expValid);
        checkOutput("busy", busy, |expValid);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("out_ch%0d", i), sampData[i], mData[i]);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mValid[i] = 1'b0;
                mData[i]  = 16'h0;
            end
            accepted.delete();
        end else begin
            acc = v && expReady;
            for (int i = 0; i < 4; i++) begin
                drained[i] = mValid[i] && ordy[i];
                if (drained[i]) begin
                    drainCount[i]++;
                    idx = -1;
                    for (int j = 0; j < accepted.size(); j++)
                        if (idx < 0 && accepted[j].ch == i) idx = j;
                    if (idx >= 0) begin
                        checkOutput($sformatf("drain_order_ch%0d", i), sampData[i], accepted[idx].data);
                        accepted.delete(idx);
                    end
                end
            end
            for (int i = 0; i < 4; i++)
                if (drained[i]) mValid[i] = 1'b0;
            if (acc) begin
                mValid[sel] = 1'b1;
                mData[sel]  = d;
                accepted.push_back('{ch: int'(sel), data: d});
            end
        end
    endtask

    initial begin
        logic [15:0] routeVals [4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 16'h0;
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            mValid[i]     = 1'b0;
            mData[i]      = 16'h0;
            drainCount[i] = 0;
        end

        // Reset held two cycles with a transfer offered.
        applyStimulus(1'b1, 1'b1, 2'd0, 16'hDEAD, 4'h0);
        applyStimulus(1'b1, 1'b1, 2'd0, 16'hDEAD, 4'h0);
        #2;
        checkOutput("reset_valid", out_valid, 4'b0000);
        checkOutput("reset_out_a", out_a, 16'h0000);

        // After reset every select is ready.
        for (int s = 0; s < 4; s++)
            applyStimulus(1'b0, 1'b0, 2'(s), 16'h0, 4'h0);

        // Basic routing, one word per channel.
        routeVals[0] = 16'h1111;
        routeVals[1] = 16'h2222;
        routeVals[2] = 16'h3333;
        routeVals[3] = 16'h4444;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 1'b1, 2'(s), routeVals[s], 4'h0);
            #2;
            checkOutput($sformatf("route_ch%0d", s), dutOut(s), routeVals[s]);
        end
        checkOutput("route_all_valid", out_valid, 4'b1111);
        checkOutput("route_busy", busy, 1'b1);

        // Back-pressure on channel c, then a different channel goes through.
        applyStimulus(1'b0, 1'b1, CH_C, 16'h5555, 4'h0);
        #2;
        checkOutput("bp_c_hold", out_c, 16'h3333);
        applyStimulus(1'b0, 1'b1, CH_A, 16'h7777, 4'b0001);
        #2;
        checkOutput("bp_a_accept", out_a, 16'h7777);

        // Drain and load channel b on the same edge.
        applyStimulus(1'b0, 1'b1, CH_B, 16'h6666, 4'b0010);
        #2;
        checkOutput("dl_b_data", out_b, 16'h6666);
        checkOutput("dl_b_valid", out_valid[1], 1'b1);

        // Streaming eight words through channel d.
        drainCount[3] = 0;
        for (int k = 1; k <= 8; k++)
            applyStimulus(1'b0, 1'b1, CH_D, 16'(k), 4'b1000);
        applyStimulus(1'b0, 1'b0, CH_D, 16'h0, 4'b1000);
        checkOutput("stream_drains", drainCount[3], 9);
        #2;
        checkOutput("stream_empty", out_valid[3], 1'b0);
        checkOutput("stream_last", out_d, 16'h0008);

        // Reset mid-operation with a and c holding data.
        applyStimulus(1'b1, 1'b1, CH_B, 16'hBEEF, 4'h0);
        #2;
        checkOutput("midreset_valid", out_valid, 4'b0000);
        applyStimulus(1'b0, 1'b1, CH_C, 16'hABCD, 4'h0);
        #2;
        checkOutput("midreset_route", out_c, 16'hABCD);
        checkOutput("midreset_vec", out_valid, 4'b0100);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++)
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom),
                          2'($urandom), 16'($urandom), 4'($urandom));
        for (int n = 0; n < 2; n++)
            applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'hF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_bus_demux_4out

// File: doc/bus_demux_4out.md
# bus_demux_4out

Four-output bus distributor: accepts one 16-bit word per cycle with a 2-bit destination select and delivers it to one of four output channels. Each channel has a one-entry holding register with valid/ready handshaking. It is the inverse of the CPU datapath's four-input bus mux: one source bus fans out to four destination consumers (register-file write port, memory data-in, I/O port, ALU operand latch), and a stalled consumer does not block the others.

## Interface
- WIDTH, 16, data width of input and every output channel

- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDTH  source word
- in_sel  in  2  destination: 0→a, 1→b, 2→c, 3→d
- in_valid  in  1  source offers in_data/in_sel this cycle
- in_ready  out  1  block accepts the offered word this cycle
- out_a, out_b, out_c, out_d  out  WIDTH  channel data, registered
- out_valid  out  4  per-channel data valid; bit i corresponds to channel i (a=0 … d=3)
- out_ready  in  4  per-channel consumer ready
- busy  out  1  OR of out_valid

## Operation
- Input transfer: occurs when in_valid && in_ready at a rising edge.
- Output transfer on channel i: occurs when out_valid[i] && out_ready[i] at a rising edge.
- Slot i is free when out_valid[i]==0, or when out_ready[i]==1 (being drained this cycle).
- in_ready = !reset && slot[in_sel] free.
  - in_ready depends combinationally on in_sel and out_ready[in_sel] only.
  - in_ready is independent of in_valid.
- On an input transfer:
  - out_<in_sel> <= in_data.
  - out_valid[in_sel] <= 1.
  - Other channels are unaffected.
- On an output transfer on channel i with no simultaneous load of i: out_valid[i] <= 0.
  - out_<i> holds its last value; data is not cleared.
- Simultaneous drain and load of the same channel: the new word replaces the old and out_valid[i] stays 1. No bubble; sustains one word/cycle per channel.
- While out_valid[i] && !out_ready[i], out_<i> and out_valid[i] are held stable.
- Ordering:
  - Words to the same channel are delivered in acceptance order.
  - No ordering is guaranteed across channels.
- in_sel and in_data are ignored when in_valid==0.
- No word is ever dropped or duplicated.
- busy = |out_valid.

## Timing
- Reset (synchronous, sampled on the rising clk edge while reset==1):
  - out_valid = 4'b0000.
  - out_a..out_d = 0.
  - busy = 0.
  - in_ready = 0 while reset is high.
- First cycle after reset deasserts: in_ready = 1 for any in_sel.
- Reset mid-operation: all held words are discarded. A transfer presented in the reset cycle is not accepted.
- Latency: a word accepted at edge N appears on out_<sel> with out_valid set after edge N, and is visible during cycle N+1.
- Throughput: one input word per cycle when the target slot is free. Back-to-back words to the same channel need out_ready held high.
- Back-pressure: input stalls only when the selected channel is full and not draining. A different in_sel in the next cycle may be accepted immediately.
- Combinational paths:
  - out_ready → in_ready.
  - in_sel → in_ready.
  - No path from in_data to any output.

## Structure
- Shared package holds:
  - WIDTH default (16).
  - Channel count constant (4).
  - Select encodings CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3, also used by the four-input bus mux select.
- Sub-module bus_demux_slot: one-entry holding register.
  - Ports: clk, reset, load, load_data, drain_ready → data, valid, free.
  - Instantiated four times.
- Top level contains only:
  - A 2→4 load decoder: load[i] = in_valid && in_ready && in_sel==i.
  - The in_ready select mux.
  - The busy OR.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_sel=0, in_data=16'hDEAD → in_ready=0, out_valid=0000, out_a=0. Release reset → in_ready=1.
- Basic routing: send 16'h1111/sel0, 16'h2222/sel1, 16'h3333/sel2, 16'h4444/sel3 on consecutive cycles with out_ready=0000 → each appears one cycle after acceptance. Final out_valid=1111, outputs hold values, busy=1.
- Back-pressure isolation: channel c full with out_ready[2]=0.
  - Offer 16'h5555/sel2 → in_ready=0 and out_c stays 16'h3333.
  - Switch to sel0 → accepted the same cycle.
- Simultaneous drain and load: out_ready[1]=1 with out_b=16'h2222 valid; send 16'h6666/sel1 → accepted. Next cycle out_b=16'h6666, out_valid[1]=1 with no gap.
- Streaming: 8 words 16'h0001..16'h0008 to sel3 with out_ready[3]=1 → 8 output transfers in 8 consecutive cycles, in order, no loss or duplication.
- Reset mid-operation: with channels a and c holding data, assert reset for 1 cycle → out_valid=0000. The next accepted word routes correctly.
